// File: rtl/stage28_pixel_packer_if.sv
// ---------------------------------------------------------------------------
// stage28_pixel_packer_if
//
// Purpose: bundles the channel-input handshake, frame control and packed
// pixel output of stage28_pixel_packer into one interface.
//
// Signals:
//   start     frame start request (honoured only while the packer is idle)
//   stall     downstream hold; forces in_ready low
//   in_valid  in_data holds a channel value
//   in_data   signed channel value, CH_W bits
//   in_ready  packer can accept in_data this cycle
//   out_data  packed pixel word, CH_W*CH_NUM bits
//   out_valid out_data is a real pixel this cycle
//   out_col   column index of out_data
//   out_row   row index of out_data
//   out_last  out_data is the final pixel of the frame
//   busy      packer is packing or draining
//   done      one-cycle pulse at the end of the drain period
//
// Modports:
//   master  frame source / sink side (drives start, stall, in_valid, in_data)
//   slave   the packer itself
// ---------------------------------------------------------------------------
interface stage28_pixel_packer_if #(
  parameter int CH_W   = 16,
  parameter int CH_NUM = 3,
  parameter int POS_W  = 5
);

  logic                      start;
  logic                      stall;
  logic                      in_valid;
  logic signed [CH_W-1:0]    in_data;
  logic                      in_ready;
  logic [CH_W*CH_NUM-1:0]    out_data;
  logic                      out_valid;
  logic [POS_W-1:0]          out_col;
  logic [POS_W-1:0]          out_row;
  logic                      out_last;
  logic                      busy;
  logic                      done;

  modport master (
    output start,
    output stall,
    output in_valid,
    output in_data,
    input  in_ready,
    input  out_data,
    input  out_valid,
    input  out_col,
    input  out_row,
    input  out_last,
    input  busy,
    input  done
  );

  modport slave (
    input  start,
    input  stall,
    input  in_valid,
    input  in_data,
    output in_ready,
    output out_data,
    output out_valid,
    output out_col,
    output out_row,
    output out_last,
    output busy,
    output done
  );

endinterface

// File: rtl/stage28_pixel_packer.sv
// ---------------------------------------------------------------------------
// stage28_pixel_packer
//
// Purpose: accepts a serial stream of signed channel values over a
// valid/ready handshake and packs every CH_NUM consecutive channels into one
// pixel word (first channel in the most significant slot). Each word is
// tagged with its column/row position in a COLS x ROWS feature map. After the
// final pixel of a frame the block idles for DRAIN_CYC cycles so the
// free-running delay line downstream can flush, then pulses done.
//
// Ports:
//   clk   rising-edge clock
//   rst   synchronous, active-low reset
//   bus   stage28_pixel_packer_if.slave (handshake, control, pixel output)
//
// Optional build macro:
//   STAGE28_PACK_RELU_EN  when defined, negative channel values are stored
//                         as zero; non-negative values pass unchanged.
//                         Handshake, latency and counters are unaffected.
//
// Output behaviour: out_valid is high for exactly one cycle per word, and
// out_data is forced to zero on every other cycle because the downstream
// delay line shifts every cycle. out_col/out_row/out_last hold their last
// values between words.
// ---------------------------------------------------------------------------
module stage28_pixel_packer #(
  parameter int CH_W      = 16,
  parameter int CH_NUM    = 3,
  parameter int COLS      = 28,
  parameter int ROWS      = 28,
  parameter int DRAIN_CYC = 29
) (
  input  logic                  clk,
  input  logic                  rst,
  stage28_pixel_packer_if.slave bus
);

  localparam int WORD_W   = CH_W * CH_NUM;
  localparam int POS_W    = 5;
  localparam int CH_CNT_W = (CH_NUM > 1) ? $clog2(CH_NUM) : 1;
  localparam int DRAIN_W  = (DRAIN_CYC > 1) ? $clog2(DRAIN_CYC) : 1;

  localparam logic [CH_CNT_W-1:0] CH_LAST    = CH_CNT_W'(CH_NUM - 1);
  localparam logic [POS_W-1:0]    COL_LAST   = POS_W'(COLS - 1);
  localparam logic [POS_W-1:0]    ROW_LAST   = POS_W'(ROWS - 1);
  localparam logic [DRAIN_W-1:0]  DRAIN_LAST = DRAIN_W'(DRAIN_CYC - 1);
  // Drain count one cycle before the last; done is registered so it is
  // raised on this count and therefore visible while drain_cnt==DRAIN_LAST.
  localparam logic [DRAIN_W-1:0]  DRAIN_PRE  = DRAIN_W'((DRAIN_CYC > 1) ? DRAIN_CYC - 2 : 0);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    PACK  = 2'd1,
    DRAIN = 2'd2
  } state_t;

  state_t                state;
  logic [CH_CNT_W-1:0]   ch_cnt;
  logic [POS_W-1:0]      col_cnt;
  logic [POS_W-1:0]      row_cnt;
  logic [DRAIN_W-1:0]    drain_cnt;

  logic [WORD_W-1:0]     part_p0;
  logic signed [CH_W-1:0] ch_val_p0;
  logic [WORD_W-1:0]     word_p0;
  logic                  in_ready;
  logic                  take;
  logic                  word_end;
  logic                  frame_end;

  logic [WORD_W-1:0]     out_data_p1;
  logic                  out_valid_p1;
  logic [POS_W-1:0]      out_col_p1;
  logic [POS_W-1:0]      out_row_p1;
  logic                  out_last_p1;
  logic                  busy_r;
  logic                  done_r;

  // Optional clamp of negative channel values to zero.
  function automatic logic signed [CH_W-1:0] relu_clamp(input logic signed [CH_W-1:0] v);
`ifdef STAGE28_PACK_RELU_EN
    relu_clamp = v[CH_W-1] ? '0 : v;
`else
    relu_clamp = v;
`endif
  endfunction

  // ---- stage p0: handshake and slot insertion into the partial word ----
  assign in_ready  = (state == PACK) && !bus.stall;
  assign take      = bus.in_valid && in_ready;
  assign ch_val_p0 = relu_clamp(bus.in_data);
  assign word_end  = take && (ch_cnt == CH_LAST);
  assign frame_end = word_end && (col_cnt == COL_LAST) && (row_cnt == ROW_LAST);

  // Slot k occupies the k-th most significant CH_W bits of the word.
  always_comb begin
    word_p0 = part_p0;
    for (int k = 0; k < CH_NUM; k++) begin
      if (ch_cnt == CH_CNT_W'(k)) begin
        word_p0[(CH_NUM-1-k)*CH_W +: CH_W] = ch_val_p0;
      end
    end
  end

  // ---- stage p1: FSM, position counters and registered pixel output ----
  always_ff @(posedge clk) begin
    if (!rst) begin
      state        <= IDLE;
      ch_cnt       <= '0;
      col_cnt      <= '0;
      row_cnt      <= '0;
      drain_cnt    <= '0;
      part_p0      <= '0;
      out_data_p1  <= '0;
      out_valid_p1 <= 1'b0;
      out_col_p1   <= '0;
      out_row_p1   <= '0;
      out_last_p1  <= 1'b0;
      busy_r       <= 1'b0;
      done_r       <= 1'b0;
    end else begin
      out_valid_p1 <= 1'b0;
      out_data_p1  <= '0;

      case (state)
        IDLE: begin
          done_r <= 1'b0;
          if (bus.start) begin
            state  <= PACK;
            busy_r <= 1'b1;
          end
        end

        PACK: begin
          if (take) begin
            if (word_end) begin
              out_valid_p1 <= 1'b1;
              out_data_p1  <= word_p0;
              out_col_p1   <= col_cnt;
              out_row_p1   <= row_cnt;
              out_last_p1  <= frame_end;
              part_p0      <= '0;
              ch_cnt       <= '0;

              if (col_cnt == COL_LAST) begin
                col_cnt <= '0;
                row_cnt <= (row_cnt == ROW_LAST) ? '0 : row_cnt + 1'b1;
              end else begin
                col_cnt <= col_cnt + 1'b1;
              end

              if (frame_end) begin
                state     <= DRAIN;
                drain_cnt <= '0;
                done_r    <= (DRAIN_CYC == 1);
              end
            end else begin
              part_p0 <= word_p0;
              ch_cnt  <= ch_cnt + 1'b1;
            end
          end
        end

        DRAIN: begin
          if (drain_cnt == DRAIN_LAST) begin
            state     <= IDLE;
            busy_r    <= 1'b0;
            done_r    <= 1'b0;
            drain_cnt <= '0;
          end else begin
            drain_cnt <= drain_cnt + 1'b1;
            done_r    <= (drain_cnt == DRAIN_PRE);
          end
        end

        default: begin
          state  <= IDLE;
          busy_r <= 1'b0;
          done_r <= 1'b0;
        end
      endcase
    end
  end

  assign bus.in_ready  = in_ready;
  assign bus.out_data  = out_data_p1;
  assign bus.out_valid = out_valid_p1;
  assign bus.out_col   = out_col_p1;
  assign bus.out_row   = out_row_p1;
  assign bus.out_last  = out_last_p1;
  assign bus.busy      = busy_r;
  assign bus.done      = done_r;

endmodule

// File: tb/tb_stage28_pixel_packer.sv
// ---------------------------------------------------------------------------
// tb_stage28_pixel_packer
//
// Self-checking bench for stage28_pixel_packer. A frame-level reference model
// (transfer count, channel queue, pixel index -> column/row arithmetic) runs
// on the falling edge alongside the DUT and every output is compared each
// cycle. Directed sequences pin literal pixel values, stall behaviour, drain
// length and mid-frame reset; the bulk of the frame uses random valid, stall,
// start and data.
// ---------------------------------------------------------------------------
module tb_stage28_pixel_packer;

  localparam int COLS  = 28;
  localparam int ROWS  = 28;
  localparam int CH    = 3;
  localparam int DRAIN = 29;
  localparam int PIXELS = COLS * ROWS;
  localparam int TOTAL  = PIXELS * CH;

`ifdef STAGE28_PACK_RELU_EN
  localparam bit RELU_ON = 1'b1;
`else
  localparam bit RELU_ON = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  stage28_pixel_packer_if bus();

  stage28_pixel_packer dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  int total = 0;
  int bad   = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at t=%0t", name, act, req, $time);
    end
  endtask

  // ---------------- reference model ----------------
  // m_frame: -1 idle, 0..TOTAL-1 transfers taken while packing, TOTAL draining
  int          m_frame = -1;
  int          m_didx  = 0;
  logic [15:0] m_q[$];
  bit          m_init  = 1'b0;

  logic        e_valid = 1'b0;
  logic [47:0] e_data  = '0;
  logic [4:0]  e_col   = '0;
  logic [4:0]  e_row   = '0;
  logic        e_last  = 1'b0;
  logic        e_busy  = 1'b0;
  logic        e_done  = 1'b0;

  int pix_seen  = 0;
  int last_seen = 0;
  int done_seen = 0;

  function automatic logic [15:0] m_relu(input logic [15:0] v);
    return (RELU_ON && v[15]) ? 16'h0000 : v;
  endfunction

  task automatic model_step();
    int pix;
    if (!rst) begin
      m_frame = -1; m_didx = 0; m_q.delete();
      e_valid = 0; e_data = '0; e_col = '0; e_row = '0;
      e_last = 0; e_busy = 0; e_done = 0;
      m_init = 1'b1;
    end else begin
      e_valid = 0; e_data = '0; e_done = 0;
      if (m_frame < 0) begin
        if (bus.start) begin
          m_frame = 0;
          e_busy  = 1;
        end
      end else if (m_frame < TOTAL) begin
        if (bus.in_valid && !bus.stall) begin
          m_q.push_back(m_relu(bus.in_data));
          m_frame++;
          if (m_q.size() == CH) begin
            pix     = m_frame / CH - 1;
            e_valid = 1;
            e_data  = {m_q[0], m_q[1], m_q[2]};
            e_col   = 5'(pix % COLS);
            e_row   = 5'(pix / COLS);
            e_last  = (pix == PIXELS - 1);
            m_q.delete();
            if (m_frame == TOTAL) begin
              m_didx = 0;
              e_done = (DRAIN == 1);
            end
          end
        end
      end else begin
        if (m_didx == DRAIN - 1) begin
          m_frame = -1;
          e_busy  = 0;
        end else begin
          m_didx++;
          e_done = (m_didx == DRAIN - 1);
        end
      end
    end
  endtask

  // Compare process: check outputs of the last edge, then predict the next.
  always @(negedge clk) begin
    if (m_init) begin
      check("in_ready",  bus.in_ready,  (m_frame >= 0 && m_frame < TOTAL && !bus.stall));
      check("out_valid", bus.out_valid, e_valid);
      check("out_data",  bus.out_data,  e_data);
      check("out_col",   bus.out_col,   e_col);
      check("out_row",   bus.out_row,   e_row);
      check("out_last",  bus.out_last,  e_last);
      check("busy",      bus.busy,      e_busy);
      check("done",      bus.done,      e_done);
    end
    if (bus.out_valid) pix_seen++;
    if (bus.out_valid && bus.out_last) last_seen++;
    if (bus.done) done_seen++;
    model_step();
  end

  // ---------------- stimulus ----------------
  task automatic put(input logic [15:0] v);
    bus.in_valid = 1'b1;
    bus.in_data  = v;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
  endtask

  task automatic feed_until(input int target);
    int budget = 20000;
    while (m_frame < target && budget > 0) begin
      bus.in_valid = ($urandom_range(0, 3) != 0);
      bus.stall    = ($urandom_range(0, 5) == 0);
      bus.start    = ($urandom_range(0, 7) == 0);
      bus.in_data  = 16'($urandom);
      @(posedge clk); #1;
      budget--;
    end
    bus.in_valid = 1'b0;
    bus.stall    = 1'b0;
    bus.start    = 1'b0;
    check("feed_reached", (m_frame == target), 1'b1);
  endtask

  task automatic pulse_start();
    bus.start = 1'b1;
    @(posedge clk); #1;
    bus.start = 1'b0;
  endtask

  initial begin
    int n;
    bus.start = 0; bus.stall = 0; bus.in_valid = 0; bus.in_data = '0;
    rst = 1'b0;

    // Reset held for three edges: outputs at reset values.
    repeat (3) @(posedge clk);
    #1;
    check("rst_out_valid", bus.out_valid, 1'b0);
    check("rst_out_data",  bus.out_data,  48'h0);
    check("rst_busy",      bus.busy,      1'b0);
    check("rst_in_ready",  bus.in_ready,  1'b0);
    check("rst_done",      bus.done,      1'b0);

    // Start a frame; busy and in_ready follow one cycle later.
    rst = 1'b1;
    pulse_start();
    check("start_busy",     bus.busy,     1'b1);
    check("start_in_ready", bus.in_ready, 1'b1);

    // Pixel 0: three back-to-back channels.
    put(16'h0001); put(16'h0002); put(16'h0003);
    check("px0_valid", bus.out_valid, 1'b1);
    check("px0_data",  bus.out_data,  48'h0001_0002_0003);
    check("px0_col",   bus.out_col,   5'd0);
    check("px0_row",   bus.out_row,   5'd0);

    // Pixel 1: stall mid-word with in_valid held high.
    put(16'hAAAA);
    bus.stall    = 1'b1;
    bus.in_valid = 1'b1;
    bus.in_data  = 16'hBBBB;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check("stall_in_ready", bus.in_ready, 1'b0);
      @(posedge clk); #1;
    end
    bus.stall = 1'b0;
    put(16'hBBBB); put(16'hCCCC);
    check("px1_valid", bus.out_valid, 1'b1);
`ifdef STAGE28_PACK_RELU_EN
    check("px1_data",  bus.out_data,  48'h0000_0000_0000);
`else
    check("px1_data",  bus.out_data,  48'hAAAA_BBBB_CCCC);
`endif
    check("px1_col",   bus.out_col,   5'd1);

    // Pixel 2: sign boundary values.
    put(16'hFFFF); put(16'h7FFF); put(16'h8000);
    check("px2_valid", bus.out_valid, 1'b1);
`ifdef STAGE28_PACK_RELU_EN
    check("px2_data",  bus.out_data,  48'h0000_7FFF_0000);
`else
    check("px2_data",  bus.out_data,  48'hFFFF_7FFF_8000);
`endif
    check("px2_col",   bus.out_col,   5'd2);

    // Rest of the frame with random traffic.
    feed_until(TOTAL);

    // Drain: done on the DRAIN-th cycle after the last transfer, stall ignored.
    bus.stall = 1'b1;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!bus.done && n < 100);
    check("drain_len", n, DRAIN);
    bus.stall = 1'b0;
    @(posedge clk); #1;
    check("frame_pixels", pix_seen,  PIXELS);
    check("frame_last",   last_seen, 1);
    check("end_busy",     bus.busy,  1'b0);
    check("done_count1",  done_seen, 1);

    // Second frame, reset in the middle of pixel 100.
    pulse_start();
    feed_until(301);
    rst = 1'b0;
    @(posedge clk); #1;
    rst = 1'b1;
    check("mrst_busy",     bus.busy,     1'b0);
    check("mrst_in_ready", bus.in_ready, 1'b0);
    check("mrst_col",      bus.out_col,  5'd0);
    check("mrst_row",      bus.out_row,  5'd0);
    repeat (40) @(posedge clk);
    #1;
    check("mrst_no_done",  done_seen, 1);

    // Restart from (0,0).
    pulse_start();
    put(16'h1234); put(16'h0567); put(16'h7ABC);
    check("restart_valid", bus.out_valid, 1'b1);
    check("restart_data",  bus.out_data,  48'h1234_0567_7ABC);
    check("restart_col",   bus.out_col,   5'd0);
    check("restart_row",   bus.out_row,   5'd0);

    repeat (3) @(posedge clk);
    #1;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #600000;
    $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
    $fatal(1, "watchdog");
  end

endmodule
